// File: rtl/pyc_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : pyc_mem_arb
// Description : Round-robin N-master to 1-slave memory request arbiter with
//               in-order response routing through a route FIFO.
//               Optional per-master grant counters: PYC_MEM_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pyc_mem_arb #(
    parameter int NUM_MASTERS     = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int STRB_WIDTH     = (DATA_WIDTH + 7) / 8,
    localparam int CNT_WIDTH      = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req_valid,
    output logic [NUM_MASTERS-1:0]            m_req_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_req_addr,
    input  logic [NUM_MASTERS-1:0]            m_req_write,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_req_wdata,
    input  logic [NUM_MASTERS*STRB_WIDTH-1:0] m_req_wstrb,
    output logic [NUM_MASTERS-1:0]            m_resp_valid,
    input  logic [NUM_MASTERS-1:0]            m_resp_ready,
    output logic [DATA_WIDTH-1:0]             m_resp_rdata,
    output logic                              s_req_valid,
    input  logic                              s_req_ready,
    output logic [ADDR_WIDTH-1:0]             s_req_addr,
    output logic                              s_req_write,
    output logic [DATA_WIDTH-1:0]             s_req_wdata,
    output logic [STRB_WIDTH-1:0]             s_req_wstrb,
    input  logic                              s_resp_valid,
    output logic                              s_resp_ready,
    input  logic [DATA_WIDTH-1:0]             s_resp_rdata,
    output logic [CNT_WIDTH-1:0]              outstanding,
    output logic [NUM_MASTERS*32-1:0]         perf_grants
);

    localparam int c_idx_w = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int c_sum_w = c_idx_w + 1;
    localparam int c_ptr_w = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [c_idx_w-1:0]   r_rr_ptr;
    logic                 r_lock;
    logic [c_idx_w-1:0]   r_lock_idx;
    logic [c_idx_w-1:0]   r_route [MAX_OUTSTANDING];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_rr_found;
    logic [c_idx_w-1:0]   w_rr_idx;
    logic [c_sum_w-1:0]   w_cand;
    logic                 w_grant_any;
    logic [c_idx_w-1:0]   w_grant_idx;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [c_idx_w-1:0]   w_head;
    logic                 w_push;
    logic                 w_pop;

    // Lowest rotated offset wins: scan from the far end so the nearest hit overwrites.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_rr_ptr} + c_sum_w'(k);
            if (w_cand >= c_sum_w'(NUM_MASTERS)) begin
                w_cand = w_cand - c_sum_w'(NUM_MASTERS);
            end
            if (m_req_valid[w_cand[c_idx_w-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand[c_idx_w-1:0];
            end
        end
    end

    assign w_grant_idx  = r_lock ? r_lock_idx : w_rr_idx;
    assign w_grant_any  = r_lock ? m_req_valid[r_lock_idx] : w_rr_found;
    assign w_fifo_full  = (r_count == CNT_WIDTH'(MAX_OUTSTANDING));
    assign w_fifo_empty = (r_count == '0);
    assign w_head       = r_route[r_rd_ptr];

    assign s_req_valid  = !rst && w_grant_any && !w_fifo_full;
    assign s_resp_ready = !rst && !w_fifo_empty && m_resp_ready[w_head];
    assign w_push       = s_req_valid && s_req_ready;
    assign w_pop        = s_resp_valid && s_resp_ready;
    assign m_resp_rdata = s_resp_rdata;
    assign outstanding  = r_count;

    always_comb begin
        s_req_addr  = '0;
        s_req_write = 1'b0;
        s_req_wdata = '0;
        s_req_wstrb = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_grant_idx == c_idx_w'(i)) begin
                s_req_addr  = m_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_req_write = m_req_write[i];
                s_req_wdata = m_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                s_req_wstrb = m_req_wstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
            assign m_req_ready[i]  = w_push && (w_grant_idx == c_idx_w'(i));
            assign m_resp_valid[i] = !rst && s_resp_valid && !w_fifo_empty &&
                                     (w_head == c_idx_w'(i));
        end
    endgenerate

    // Freeze the grant while the slave stalls so the presented request stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            r_lock     <= s_req_valid && !s_req_ready;
            r_lock_idx <= w_grant_idx;
            if (w_push) begin
                r_rr_ptr <= (w_grant_idx == c_idx_w'(NUM_MASTERS - 1)) ? '0
                                                                       : w_grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_route[r_wr_ptr] <= w_grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_ptr_w'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef PYC_MEM_ARB_PERF_EN
    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_perf
            logic [31:0] r_grant_cnt;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_grant_cnt <= '0;
                end else if (m_req_ready[i] && (r_grant_cnt != 32'hFFFF_FFFF)) begin
                    r_grant_cnt <= r_grant_cnt + 32'd1;
                end
            end
            assign perf_grants[i*32 +: 32] = r_grant_cnt;
        end
    endgenerate
`else
    assign perf_grants = '0;
`endif

endmodule
`default_nettype wire
